// File: rtl/uart_alici_tamponlu_pkg.sv
// Shared constants for the buffered UART receiver: parity codes, FSM states, default clocking.
package uart_alici_tamponlu_pkg;

  localparam int unsigned PariteYok  = 0;
  localparam int unsigned PariteTek  = 1;
  localparam int unsigned PariteCift = 2;

  localparam int unsigned ClkHz    = 50_000_000;
  localparam int unsigned BaudRate = 115_200;

  typedef enum logic [2:0] {
    StBos,
    StBasla,
    StVeri,
    StParite,
    StDur,
    StKopma
  } durum_e;

  function automatic logic cogunluk(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_alici_tamponlu_fifo.sv
// First-word-fall-through FIFO with synchronous reset, occupancy output and overflow strobe.
module uart_alici_tamponlu_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_en_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(DATA_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DATA_DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_rd      = rd_en_i & ~empty_o;
  assign do_wr      = wr_en_i & (~full_o | do_rd);
  assign overflow_o = wr_en_i & full_o & ~do_rd;

  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_alici_tamponlu.sv
// Oversampled UART receiver with 3-sample majority voting, parity/framing/break detection,
// saturating error counter and an RX FIFO with valid/ready read side.
module uart_alici_tamponlu
  import uart_alici_tamponlu_pkg::*;
#(
  parameter int unsigned VERI_BIT      = 8,
  parameter int unsigned PARITE        = 0,
  parameter int unsigned DUR_BIT       = 1,
  parameter int unsigned ORNEK         = 16,
  parameter int unsigned FIFO_DERINLIK = 32,
  parameter int unsigned BAUD_W        = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [BAUD_W-1:0]                  baud_div_i,
  input  logic                               rx_i,
  output logic [VERI_BIT-1:0]                veri_o,
  output logic                               gecerli_o,
  input  logic                               hazir_i,
  output logic [$clog2(FIFO_DERINLIK):0]     doluluk_o,
  output logic                               parite_hata_o,
  output logic                               cerceve_hata_o,
  output logic                               kopma_o,
  output logic                               tasma_o,
  output logic [15:0]                        hata_sayac_o
);

  localparam int unsigned Yari = ORNEK / 2;
  localparam int unsigned SmpW = $clog2(ORNEK) + 1;
  localparam int unsigned BitW = 4;

  durum_e durum_q, durum_d;

  logic [1:0]          sync_q;
  logic                rx_s, rx_prev_q;
  logic [BAUD_W-1:0]   tick_cnt_q, tick_cnt_d, reload;
  logic                tick, restart;
  logic [SmpW-1:0]     smp_q, smp_d, smp_n;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [VERI_BIT-1:0] shreg_q, shreg_d;
  logic                par_q, par_d;
  logic                stop_bad_q, stop_bad_d, stop_bad_now;
  logic [1:0]          vote_q, vote_d;
  logic                ornek_an, karar, bit_val;
  logic                sifir, par_ok;
  logic                push, par_err, frm_err, brk;
  logic                fifo_empty, fifo_full, fifo_ovf;
  logic                parite_q, cerceve_q, kopma_q, tasma_q;
  logic [15:0]         hata_q, hata_d;
  logic [2:0]          n_err;
  logic [16:0]         hata_sum;

  assign rx_s   = sync_q[1];
  assign reload = (baud_div_i == '0) ? '0 : baud_div_i - BAUD_W'(1);
  assign tick   = (tick_cnt_q == '0);

  always_comb begin
    tick_cnt_d = tick_cnt_q - BAUD_W'(1);
    if (restart || tick) tick_cnt_d = reload;
  end

  assign ornek_an = tick && (durum_q != StBos) && (durum_q != StKopma);
  assign smp_n    = smp_q + SmpW'(1);
  assign karar    = ornek_an && (smp_n == SmpW'(Yari + 1));
  assign bit_val  = cogunluk(vote_q[0], vote_q[1], rx_s);

  // A break is an all-zero frame, parity bit included, ending on a low stop sample.
  assign sifir  = (shreg_q == '0) && ((PARITE == PariteYok) || !par_q);
  assign par_ok = (PARITE == PariteYok) ? 1'b1 :
                  (PARITE == PariteTek) ? ^{shreg_q, par_q} : ~^{shreg_q, par_q};

  always_comb begin
    durum_d      = durum_q;
    smp_d        = smp_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    stop_bad_d   = stop_bad_q;
    vote_d       = vote_q;
    stop_bad_now = stop_bad_q | ~bit_val;
    restart      = 1'b0;
    push         = 1'b0;
    par_err      = 1'b0;
    frm_err      = 1'b0;
    brk          = 1'b0;

    if (ornek_an) begin
      smp_d = (smp_n == SmpW'(ORNEK)) ? '0 : smp_n;
      if (smp_n == SmpW'(Yari - 1)) vote_d[0] = rx_s;
      if (smp_n == SmpW'(Yari))     vote_d[1] = rx_s;
    end

    unique case (durum_q)
      StBos: begin
        if (rx_prev_q && !rx_s) begin
          durum_d = StBasla;
          restart = 1'b1;
          smp_d   = '0;
        end
      end
      StBasla: begin
        if (karar) begin
          if (bit_val) begin
            durum_d = StBos;
          end else begin
            durum_d    = StVeri;
            bit_d      = '0;
            stop_bad_d = 1'b0;
          end
        end
      end
      StVeri: begin
        if (karar) begin
          shreg_d = {bit_val, shreg_q[VERI_BIT-1:1]};
          if (bit_q == BitW'(VERI_BIT - 1)) begin
            bit_d   = '0;
            durum_d = (PARITE != PariteYok) ? StParite : StDur;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParite: begin
        if (karar) begin
          par_d   = bit_val;
          durum_d = StDur;
        end
      end
      StDur: begin
        if (karar) begin
          if (bit_q == BitW'(DUR_BIT - 1)) begin
            if (stop_bad_now && sifir) begin
              brk     = 1'b1;
              durum_d = StKopma;
            end else begin
              durum_d = StBos;
              par_err = ~par_ok;
              frm_err = stop_bad_now;
              push    = par_ok & ~stop_bad_now;
            end
          end else begin
            bit_d      = bit_q + BitW'(1);
            stop_bad_d = stop_bad_now;
          end
        end
      end
      StKopma: begin
        if (rx_s) durum_d = StBos;
      end
      default: durum_d = StBos;
    endcase
  end

  always_comb begin
    n_err    = 3'(par_err) + 3'(frm_err) + 3'(brk) + 3'(fifo_ovf);
    hata_sum = {1'b0, hata_q} + 17'(n_err);
    hata_d   = hata_sum[16] ? 16'hFFFF : hata_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q    <= StBos;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      smp_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      stop_bad_q <= 1'b0;
      vote_q     <= 2'b11;
      parite_q   <= 1'b0;
      cerceve_q  <= 1'b0;
      kopma_q    <= 1'b0;
      tasma_q    <= 1'b0;
      hata_q     <= '0;
    end else begin
      durum_q    <= durum_d;
      sync_q     <= {sync_q[0], rx_i};
      rx_prev_q  <= rx_s;
      tick_cnt_q <= tick_cnt_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_bad_q <= stop_bad_d;
      vote_q     <= vote_d;
      parite_q   <= par_err;
      cerceve_q  <= frm_err;
      kopma_q    <= brk;
      tasma_q    <= fifo_ovf;
      hata_q     <= hata_d;
    end
  end

  uart_alici_tamponlu_fifo #(
    .DATA_WIDTH (VERI_BIT),
    .DATA_DEPTH (FIFO_DERINLIK)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (push),
    .wr_data_i  (shreg_q),
    .rd_en_i    (hazir_i),
    .rd_data_o  (veri_o),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (doluluk_o),
    .overflow_o (fifo_ovf)
  );

  assign gecerli_o      = ~fifo_empty;
  assign parite_hata_o  = parite_q;
  assign cerceve_hata_o = cerceve_q;
  assign kopma_o        = kopma_q;
  assign tasma_o        = tasma_q;
  assign hata_sayac_o   = hata_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_alici_tamponlu.sv
// Bench for uart_alici_tamponlu: 8N1, 8E1 and 8N2 instances; scoreboard on the 8N1 read port.
module tb_uart_alici_tamponlu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic        hazir_a = 1'b0, hazir_b = 1'b0, hazir_c = 1'b0;
  logic [7:0]  veri_a, veri_b, veri_c;
  logic        gec_a, gec_b, gec_c;
  logic [5:0]  dol_a, dol_b, dol_c;
  logic [2:0]  par_p, frm_p, brk_p, ovf_p;
  logic [15:0] hata_a, hata_b, hata_c;

  int n_chk = 0;
  int n_fail = 0;
  int par_n [3];
  int frm_n [3];
  int brk_n [3];
  int ovf_n [3];

  logic [7:0] exp_mem [256];
  int wr_idx = 0;
  int rd_idx = 0;

  always #5 clk = ~clk;

  uart_alici_tamponlu u_dut_a (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .rx_i(rx_a), .veri_o(veri_a),
    .gecerli_o(gec_a), .hazir_i(hazir_a), .doluluk_o(dol_a), .parite_hata_o(par_p[0]),
    .cerceve_hata_o(frm_p[0]), .kopma_o(brk_p[0]), .tasma_o(ovf_p[0]), .hata_sayac_o(hata_a)
  );

  uart_alici_tamponlu #(.PARITE(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .rx_i(rx_b), .veri_o(veri_b),
    .gecerli_o(gec_b), .hazir_i(hazir_b), .doluluk_o(dol_b), .parite_hata_o(par_p[1]),
    .cerceve_hata_o(frm_p[1]), .kopma_o(brk_p[1]), .tasma_o(ovf_p[1]), .hata_sayac_o(hata_b)
  );

  uart_alici_tamponlu #(.DUR_BIT(2)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .rx_i(rx_c), .veri_o(veri_c),
    .gecerli_o(gec_c), .hazir_i(hazir_c), .doluluk_o(dol_c), .parite_hata_o(par_p[2]),
    .cerceve_hata_o(frm_p[2]), .kopma_o(brk_p[2]), .tasma_o(ovf_p[2]), .hata_sayac_o(hata_c)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (par_p[i]) par_n[i] = par_n[i] + 1;
      if (frm_p[i]) frm_n[i] = frm_n[i] + 1;
      if (brk_p[i]) brk_n[i] = brk_n[i] + 1;
      if (ovf_p[i]) ovf_n[i] = ovf_n[i] + 1;
    end
  end

  // Scoreboard monitor: every handshake on instance A pops one expected byte.
  always @(negedge clk) begin
    if (rst) begin
      rd_idx = wr_idx;
    end else if (gec_a && hazir_a) begin
      n_chk = n_chk + 1;
      if (rd_idx == wr_idx) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_unexpected: got byte %02h, none expected", veri_a);
      end else begin
        if (veri_a !== exp_mem[rd_idx[7:0]]) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_data[%0d]: got %02h, expected %02h", rd_idx, veri_a,
                   exp_mem[rd_idx[7:0]]);
        end
        rd_idx = rd_idx + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_mem[wr_idx[7:0]] = b;
    wr_idx = wr_idx + 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gecerli"}, 32'(gec_a), 32'd0);
    chk({tag, "_doluluk"}, 32'(dol_a), 32'd0);
    chk({tag, "_veri"}, 32'(veri_a), 32'd0);
    chk({tag, "_hata"}, 32'(hata_a), 32'd0);
    chk({tag, "_pulses"}, 32'({par_p[0], frm_p[0], brk_p[0], ovf_p[0]}), 32'd0);
  endtask

  // One frame at 64 clk/bit: start, 8 data LSB first, optional parity, nstop stop bits.
  // rst_bit >= 0 pulses reset half-way through that bit position.
  task automatic send_frame(input int inst, input logic [7:0] data, input bit has_par,
                            input logic par, input int nstop, input logic [1:0] stopv,
                            input int rst_bit);
    logic [11:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    nb = 9;
    if (has_par) begin
      bits[nb] = par;
      nb++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[nb] = stopv[s];
      nb++;
    end
    for (int k = 0; k < nb; k++) begin
      set_rx(inst, bits[k]);
      if (k == rst_bit) begin
        cyc(32);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        cyc(31);
      end else begin
        cyc(64);
      end
    end
    set_rx(inst, 1'b1);
    cyc(64);
  endtask

  int b_par, b_frm, b_brk, b_ovf, t;

  initial begin
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_b_gecerli", 32'(gec_b), 32'd0);
    chk("reset_c_doluluk", 32'(dol_c), 32'd0);
    cyc(1);

    // 8N1 0xA5, held until explicitly popped
    expect_byte(8'hA5);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, -1);
    chk("a5_doluluk", 32'(dol_a), 32'd1);
    chk("a5_gecerli", 32'(gec_a), 32'd1);
    hazir_a = 1'b1;
    cyc(1);
    hazir_a = 1'b0;
    cyc(1);
    chk("a5_pop_doluluk", 32'(dol_a), 32'd0);

    // Fill: 33 frames with no consumer, the 33rd overflows
    b_ovf = ovf_n[0];
    for (int v = 0; v <= 32; v++) begin
      if (v < 32) expect_byte(8'(v));
      send_frame(0, 8'(v), 1'b0, 1'b0, 1, 2'b11, -1);
    end
    chk("fill_doluluk", 32'(dol_a), 32'd32);
    chk("fill_tasma", 32'(ovf_n[0] - b_ovf), 32'd1);
    chk("fill_hata", 32'(hata_a), 32'd1);
    hazir_a = 1'b1;
    t = 0;
    while (dol_a != 6'd0 && t < 200) begin
      cyc(1);
      t++;
    end
    chk("drain_doluluk", 32'(dol_a), 32'd0);
    chk("drain_sb", 32'(wr_idx - rd_idx), 32'd0);

    // Glitch shorter than half a bit: a false start
    b_par = par_n[0]; b_frm = frm_n[0]; b_brk = brk_n[0]; b_ovf = ovf_n[0];
    rx_a = 1'b0;
    cyc(8);
    rx_a = 1'b1;
    cyc(700);
    chk("glitch_pulses", 32'((par_n[0] - b_par) + (frm_n[0] - b_frm) + (brk_n[0] - b_brk)
                             + (ovf_n[0] - b_ovf)), 32'd0);
    chk("glitch_doluluk", 32'(dol_a), 32'd0);

    // Break: line low for 12 bit-times, then a normal frame
    hazir_a = 1'b0;
    b_frm = frm_n[0]; b_brk = brk_n[0];
    rx_a = 1'b0;
    cyc(768);
    rx_a = 1'b1;
    cyc(128);
    chk("break_kopma", 32'(brk_n[0] - b_brk), 32'd1);
    chk("break_cerceve", 32'(frm_n[0] - b_frm), 32'd0);
    chk("break_doluluk", 32'(dol_a), 32'd0);
    chk("break_hata", 32'(hata_a), 32'd2);
    expect_byte(8'h5A);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 2'b11, -1);
    chk("after_break_doluluk", 32'(dol_a), 32'd1);

    // Reset during data bit 4 clears the queued 0x5A; the all-ones tail causes no start
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1, 2'b11, 5);
    chk("post_reset_doluluk", 32'(dol_a), 32'd0);
    hazir_a = 1'b1;
    expect_byte(8'h3C);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11, -1);
    chk("post_reset_sb", 32'(wr_idx - rd_idx), 32'd0);

    // 8E1: 0x03 has even data parity, so a parity bit of 1 is wrong
    b_par = par_n[1]; b_frm = frm_n[1];
    send_frame(1, 8'h03, 1'b1, 1'b1, 1, 2'b11, -1);
    chk("par_pulse", 32'(par_n[1] - b_par), 32'd1);
    chk("par_doluluk", 32'(dol_b), 32'd0);
    chk("par_hata", 32'(hata_b), 32'd1);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1, 2'b11, -1);
    chk("par_good_gecerli", 32'(gec_b), 32'd1);
    chk("par_good_veri", 32'(veri_b), 32'h03);
    // Parity and framing wrong together: both pulse, counter +2
    send_frame(1, 8'h81, 1'b1, 1'b1, 1, 2'b10, -1);
    chk("par_frm_par", 32'(par_n[1] - b_par), 32'd2);
    chk("par_frm_frm", 32'(frm_n[1] - b_frm), 32'd1);
    chk("par_frm_hata", 32'(hata_b), 32'd3);
    chk("par_frm_doluluk", 32'(dol_b), 32'd1);

    // 8N2: second stop bit low is a framing error
    b_frm = frm_n[2];
    send_frame(2, 8'h3C, 1'b0, 1'b0, 2, 2'b01, -1);
    chk("stop2_cerceve", 32'(frm_n[2] - b_frm), 32'd1);
    chk("stop2_doluluk", 32'(dol_c), 32'd0);
    chk("stop2_hata", 32'(hata_c), 32'd1);
    send_frame(2, 8'h81, 1'b0, 1'b0, 2, 2'b11, -1);
    chk("stop2_good_doluluk", 32'(dol_c), 32'd1);
    chk("stop2_good_veri", 32'(veri_c), 32'h81);

    chk("sb_drained", 32'(rd_idx), 32'(wr_idx));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
